// File: rtl/vga_rx_monitor_pkg.sv
// Shared 640x480@60 timing constants, lock-state encoding and helpers for the
// VGA receive monitor. The VGA_sync generator uses the same constants.
package vga_rx_monitor_pkg;

    localparam int VGA_CLKS_PER_PIXEL = 4;
    localparam int VGA_H_TOTAL        = 800;
    localparam int VGA_H_SYNC         = 96;
    localparam int VGA_H_ACT_START    = 144;
    localparam int VGA_H_ACTIVE       = 640;
    localparam int VGA_V_TOTAL        = 525;
    localparam int VGA_V_SYNC         = 2;
    localparam int VGA_V_ACT_START    = 35;
    localparam int VGA_V_ACTIVE       = 480;
    localparam int VGA_LOCK_FRAMES    = 2;

    // Bit positions in err_flags.
    localparam int ERR_H_TOTAL  = 0;
    localparam int ERR_HS_WIDTH = 1;
    localparam int ERR_V_TOTAL  = 2;
    localparam int ERR_VS_WIDTH = 3;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_COUNTING = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_e;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7ff) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop sampler for an active-low sync input with assert/deassert pulses.
// Both flops reset low so a reset inside a sync pulse cannot fake an assert edge.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic assert_p,
    output logic deassert_p
);

    logic r1_q, r1_d;
    logic r2_q, r2_d;

    always_comb begin
        r1_d       = sync_in;
        r2_d       = r1_q;
        assert_p   = !r1_q && r2_q;
        deassert_p = r1_q && !r2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q <= 1'b0;
            r2_q <= 1'b0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA sink: recovers the pixel grid from HS, emits active pixels with
// coordinates, measures sync/line/frame lengths and tracks timing lock.
//   state        | meaning
//   LK_UNLOCKED  | no frame reference yet, or an error was just seen
//   LK_COUNTING  | counting consecutive error-free frames
//   LK_LOCKED    | LOCK_FRAMES clean frames seen, timing verified
module vga_rx_monitor
    import vga_rx_monitor_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = VGA_CLKS_PER_PIXEL,
    parameter int H_TOTAL        = VGA_H_TOTAL,
    parameter int H_SYNC         = VGA_H_SYNC,
    parameter int H_ACT_START    = VGA_H_ACT_START,
    parameter int H_ACTIVE       = VGA_H_ACTIVE,
    parameter int V_TOTAL        = VGA_V_TOTAL,
    parameter int V_SYNC         = VGA_V_SYNC,
    parameter int V_ACT_START    = VGA_V_ACT_START,
    parameter int V_ACTIVE       = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES    = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HS,
    input  logic        VS,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [3:0]  err_flags
);

    localparam logic [7:0]  PH_LAST = 8'(CLKS_PER_PIXEL - 1);
    localparam logic [7:0]  PH_MID  = 8'(CLKS_PER_PIXEL / 2);
    localparam logic [10:0] SAT     = 11'h7ff;
    localparam logic [10:0] H_LO    = 11'(H_ACT_START);
    localparam logic [10:0] H_HI    = 11'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [10:0] V_LO    = 11'(V_ACT_START);
    localparam logic [10:0] V_HI    = 11'(V_ACT_START + V_ACTIVE - 1);
    localparam logic [9:0]  X0      = 10'(H_ACT_START);
    localparam logic [9:0]  Y0      = 10'(V_ACT_START);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    logic hs_as, hs_de, vs_as, vs_de;

    vga_sync_edge u_hs_edge (.clk(clk), .rst(rst), .sync_in(HS),
                             .assert_p(hs_as), .deassert_p(hs_de));
    vga_sync_edge u_vs_edge (.clk(clk), .rst(rst), .sync_in(VS),
                             .assert_p(vs_as), .deassert_p(vs_de));

    logic [11:0] rgb_r1_q, rgb_r1_d;
    logic [7:0]  ph_q, ph_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, vs_w_q, vs_w_d;
    logic        vs_arm_q, vs_arm_d, hs_seen_q, hs_seen_d;
    logic        frame_seen_q, frame_seen_d, vs_seen_q, vs_seen_d;
    lock_state_e state_q, state_d;
    logic [7:0]  clean_q, clean_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic        timing_err_q, timing_err_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic [3:0]  err_now, err_flags_q, err_flags_d;
    logic        frame_close, in_active;

    // Lengths are compared as count+1: the closing edge is seen while ph sits
    // on the last phase of the final pixel, before hcnt/vcnt would advance.
    always_comb begin
        rgb_r1_d     = {red, green, blue};
        ph_d         = ph_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        vs_w_d       = vs_w_q;
        vs_arm_d     = vs_arm_q;
        hs_seen_d    = hs_seen_q;
        frame_seen_d = frame_seen_q;
        vs_seen_d    = vs_seen_q;
        err_now      = 4'b0000;
        frame_close  = 1'b0;

        if (hs_as) begin
            ph_d      = 8'd0;
            hcnt_d    = 11'd0;
            hs_seen_d = 1'b1;
            if (hs_seen_q && (12'(hcnt_q) + 12'd1 != 12'(H_TOTAL)))
                err_now[ERR_H_TOTAL] = 1'b1;
            if (vs_arm_q || vs_as) begin
                vcnt_d       = 11'd0;
                vs_arm_d     = 1'b0;
                frame_seen_d = 1'b1;
                frame_close  = 1'b1;
                if (frame_seen_q && (12'(vcnt_q) + 12'd1 != 12'(V_TOTAL)))
                    err_now[ERR_V_TOTAL] = 1'b1;
            end else begin
                vcnt_d = sat_inc11(vcnt_q);
            end
        end else begin
            if (ph_q == PH_LAST) begin
                ph_d   = 8'd0;
                hcnt_d = sat_inc11(hcnt_q);
            end else begin
                ph_d = ph_q + 8'd1;
            end
            if (vs_as)
                vs_arm_d = 1'b1;
        end

        if (hs_de && hs_seen_q && (12'(hcnt_q) + 12'd1 != 12'(H_SYNC)))
            err_now[ERR_HS_WIDTH] = 1'b1;

        // An HS edge coincident with the VS assert is the first line of the pulse.
        if (vs_as) begin
            vs_w_d    = hs_as ? 11'd1 : 11'd0;
            vs_seen_d = 1'b1;
        end else if (hs_as) begin
            vs_w_d = sat_inc11(vs_w_q);
        end
        if (vs_de && vs_seen_q && (vs_w_q != 11'(V_SYNC)))
            err_now[ERR_VS_WIDTH] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        if (|err_now) begin
            state_d = LK_UNLOCKED;
            clean_d = 8'd0;
        end else if (frame_close) begin
            case (state_q)
                LK_UNLOCKED: begin
                    state_d = LK_COUNTING;
                    clean_d = 8'd0;
                end
                LK_COUNTING: begin
                    clean_d = clean_q + 8'd1;
                    if (clean_q + 8'd1 >= LOCK_N)
                        state_d = LK_LOCKED;
                end
                LK_LOCKED: state_d = LK_LOCKED;
                default:   state_d = LK_UNLOCKED;
            endcase
        end
    end

    // Pixels only after both grids have a reference, so a partial line/frame
    // after reset never produces bogus coordinates.
    always_comb begin
        in_active = hs_seen_q && frame_seen_q && (hcnt_q != SAT) && (vcnt_q != SAT) &&
                    (hcnt_q >= H_LO) && (hcnt_q <= H_HI) &&
                    (vcnt_q >= V_LO) && (vcnt_q <= V_HI);
        pix_valid_d   = (ph_q == PH_MID) && in_active;
        frame_start_d = pix_valid_d && (hcnt_q == H_LO) && (vcnt_q == V_LO);
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_rgb_d     = pix_rgb_q;
        if (pix_valid_d) begin
            pix_x_d   = hcnt_q[9:0] - X0;
            pix_y_d   = vcnt_q[9:0] - Y0;
            pix_rgb_d = rgb_r1_q;
        end
        timing_err_d = |err_now;
        err_flags_d  = err_flags_q | err_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r1_q      <= '0;
            ph_q          <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            vs_w_q        <= '0;
            vs_arm_q      <= 1'b0;
            hs_seen_q     <= 1'b0;
            frame_seen_q  <= 1'b0;
            vs_seen_q     <= 1'b0;
            state_q       <= LK_UNLOCKED;
            clean_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            err_flags_q   <= '0;
        end else begin
            rgb_r1_q      <= rgb_r1_d;
            ph_q          <= ph_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            vs_w_q        <= vs_w_d;
            vs_arm_q      <= vs_arm_d;
            hs_seen_q     <= hs_seen_d;
            frame_seen_q  <= frame_seen_d;
            vs_seen_q     <= vs_seen_d;
            state_q       <= state_d;
            clean_q       <= clean_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            timing_err_q  <= timing_err_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            err_flags_q   <= err_flags_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LK_LOCKED);
    assign timing_err  = timing_err_q;
    assign err_flags   = err_flags_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a shrunken raster: an inline generator drives
// frames, expected pixels go to a queue and are popped as the DUT emits them.
module tb_vga_rx_monitor;

    localparam int CPP = 4;
    localparam int HT  = 24;
    localparam int HSW = 3;
    localparam int HAS = 6;
    localparam int HA  = 14;
    localparam int VT  = 14;
    localparam int VSW = 2;
    localparam int VAS = 4;
    localparam int VA  = 8;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HS = 1'b1;
    logic        VS = 1'b1;
    logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
    logic        pix_valid, frame_start, locked, timing_err;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [3:0]  err_flags;

    vga_rx_monitor #(
        .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS),
        .H_ACTIVE(HA), .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT_START(VAS),
        .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .HS(HS), .VS(VS),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       sb_e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pix_count = 0;
    int         fs_count = 0;
    int         err_pulses = 0;
    logic [9:0] last_x = '0;
    logic [9:0] last_y = '0;

    always @(negedge clk) begin
        if (pix_valid) begin
            pix_count++;
            if (frame_start) fs_count++;
            last_x = pix_x;
            last_y = pix_y;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pix_unexpected got x=%0d y=%0d rgb=%03h, none expected",
                         pix_x, pix_y, pix_rgb);
            end else begin
                sb_e = exp_q.pop_front();
                if ({pix_x, pix_y, pix_rgb, frame_start} !==
                    {sb_e.x, sb_e.y, sb_e.rgb, (sb_e.x == 10'd0 && sb_e.y == 10'd0)})
                    $display("FAIL pix got x=%0d y=%0d rgb=%03h fs=%0b exp x=%0d y=%0d rgb=%03h",
                             pix_x, pix_y, pix_rgb, frame_start, sb_e.x, sb_e.y, sb_e.rgb);
                else
                    n_pass++;
            end
        end
        if (timing_err) begin
            err_pulses++;
            n_checks++;
            if (locked !== 1'b0)
                $display("FAIL locked_on_err got=%0b exp=0", locked);
            else
                n_pass++;
        end
    end

    // Drives one frame starting at line 0; tasks start and end at posedge+1.
    task automatic drive_frame(input int lines, input int vs_lines, input bit exp_pix,
                               input int long_line, input int short_line);
        int          len;
        int          hw;
        logic [11:0] c;
        pix_t        e;
        for (int l = 0; l < lines; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            hw  = (l == short_line) ? HSW - 1 : HSW;
            for (int p = 0; p < len; p++) begin
                c  = 12'($urandom_range(0, 4095));
                HS = (p < hw) ? 1'b0 : 1'b1;
                VS = (l < vs_lines) ? 1'b0 : 1'b1;
                {red, green, blue} = c;
                if (exp_pix && p >= HAS && p < HAS + HA && l >= VAS && l < VAS + VA) begin
                    e.x   = 10'(p - HAS);
                    e.y   = 10'(l - VAS);
                    e.rgb = c;
                    exp_q.push_back(e);
                end
                repeat (CPP) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({pix_valid, frame_start, locked, timing_err} !== 4'b0000)
            $display("FAIL reset_strobes got=%04b exp=0000",
                     {pix_valid, frame_start, locked, timing_err});
        else n_pass++;
        n_checks++;
        if ({pix_x, pix_y, pix_rgb} !== 32'd0)
            $display("FAIL reset_pix got=%08h exp=0", {pix_x, pix_y, pix_rgb});
        else n_pass++;
        n_checks++;
        if (err_flags !== 4'b0000) $display("FAIL reset_flags got=%04b exp=0000", err_flags);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, err_flags} !== 5'd0)
            $display("FAIL idle_after_reset got=%05b exp=00000", {locked, err_flags});
        else n_pass++;
    endtask

    task automatic test_lock();
        int p0, f0;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL lock_early got=%0b exp=0", locked);
        else n_pass++;
        p0 = pix_count;
        f0 = fs_count;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_after_2 got=%0b exp=1", locked);
        else n_pass++;
        n_checks++;
        if (pix_count - p0 != HA * VA)
            $display("FAIL frame_pix_count got=%0d exp=%0d", pix_count - p0, HA * VA);
        else n_pass++;
        n_checks++;
        if (fs_count - f0 != 1) $display("FAIL frame_start_count got=%0d exp=1", fs_count - f0);
        else n_pass++;
        n_checks++;
        if ({last_x, last_y} !== {10'(HA - 1), 10'(VA - 1)})
            $display("FAIL last_pix got=(%0d,%0d) exp=(%0d,%0d)", last_x, last_y, HA - 1, VA - 1);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d left exp=0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (err_flags !== 4'b0000 || err_pulses != 0)
            $display("FAIL clean_errs got flags=%04b pulses=%0d exp 0000/0", err_flags, err_pulses);
        else n_pass++;
    endtask

    task automatic test_hs_width();
        int e0;
        e0 = err_pulses;
        drive_frame(VT, VSW, 1'b1, -1, 3);
        n_checks++;
        if (err_pulses - e0 != 1) $display("FAIL hs_err_pulses got=%0d exp=1", err_pulses - e0);
        else n_pass++;
        n_checks++;
        if (err_flags !== 4'b0010) $display("FAIL hs_flags got=%04b exp=0010", err_flags);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL hs_unlock got=%0b exp=0", locked);
        else n_pass++;
    endtask

    task automatic test_line_len();
        int e0;
        e0 = err_pulses;
        drive_frame(VT, VSW, 1'b1, 1, -1);
        n_checks++;
        if (err_pulses - e0 != 1) $display("FAIL line_err_pulses got=%0d exp=1", err_pulses - e0);
        else n_pass++;
        n_checks++;
        if (err_flags !== 4'b0011) $display("FAIL line_flags got=%04b exp=0011", err_flags);
        else n_pass++;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_early got=%0b exp=0", locked);
        else n_pass++;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if ({locked, err_flags} !== 5'b10011)
            $display("FAIL relock got=%05b exp=10011", {locked, err_flags});
        else n_pass++;
    endtask

    task automatic test_vframe();
        int e0;
        e0 = err_pulses;
        drive_frame(VT - 1, VSW + 1, 1'b1, -1, -1);
        n_checks++;
        if (err_pulses - e0 != 1 || err_flags !== 4'b1011)
            $display("FAIL vs_width got pulses=%0d flags=%04b exp 1/1011", err_pulses - e0, err_flags);
        else n_pass++;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if (err_pulses - e0 != 2) $display("FAIL vframe_pulses got=%0d exp=2", err_pulses - e0);
        else n_pass++;
        n_checks++;
        if ({locked, err_flags} !== 5'b01111)
            $display("FAIL vframe_flags got=%05b exp=01111", {locked, err_flags});
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int e0;
        fork
            drive_frame(VT, VSW, 1'b0, -1, -1);
            begin
                repeat (CPP * HT / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                n_checks++;
                if ({pix_valid, frame_start, locked, timing_err, err_flags, pix_x, pix_y, pix_rgb} !== 40'd0)
                    $display("FAIL mid_reset got=%010h exp=0",
                             {pix_valid, frame_start, locked, timing_err, err_flags, pix_x, pix_y, pix_rgb});
                else n_pass++;
            end
        join
        e0 = err_pulses;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL mid_relock_early got=%0b exp=0", locked);
        else n_pass++;
        drive_frame(VT, VSW, 1'b1, -1, -1);
        n_checks++;
        if ({locked, err_flags} !== 5'b10000 || err_pulses != e0)
            $display("FAIL mid_relock got=%05b pulses=%0d exp=10000/0",
                     {locked, err_flags}, err_pulses - e0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL mid_sb_drain got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hs_width();
        test_line_len();
        test_vframe();
        test_mid_reset();
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
